// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared state encoding and result byte offsets
package hamming_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, COMPARE, WRITE, DONE} hm_state_t;

  localparam logic [2:0] RES_MIN  = 3'd0;
  localparam logic [2:0] RES_MAX  = 3'd1;
  localparam logic [2:0] RES_MINJ = 3'd2;
  localparam logic [2:0] RES_MINK = 3'd3;
  localparam logic [2:0] RES_MAXJ = 3'd4;
  localparam logic [2:0] RES_MAXK = 3'd5;

endpackage

// File: rtl/hamming_minmax_engine_popcount.sv
// rtl/hamming_minmax_engine_popcount.sv - combinational population count of a W-bit word
module popcount_w #(
  parameter int W = 16
) (
  input  logic [W-1:0]           din,
  output logic [$clog2(W+1)-1:0] count
);

  localparam int DW = $clog2(W+1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + DW'(din[i]);
    end
  end

endmodule

// File: rtl/hamming_minmax_engine.sv
// rtl/hamming_minmax_engine.sv - min/max pairwise Hamming distance over N words in byte memory
module hamming_minmax_engine
  import hamming_pkg::*;
#(
  parameter int W        = 16,
  parameter int N        = 32,
  parameter int AW       = 8,
  parameter int SRC_BASE = 0,
  parameter int RES_BASE = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
);

  localparam int B  = W / 8;
  localparam int DW = $clog2(W + 1);
  localparam int IW = $clog2(N);
  localparam int NB = N * B;

  if (DW > 8 || IW > 8 || (W % 8) != 0 || N < 2) begin : g_bad_params
    $error("hamming_minmax_engine: unsupported W/N combination");
  end

  hm_state_t         state, nstate;
  logic [15:0]       cnt;
  logic [IW-1:0]     j, k;
  logic [N*W-1:0]    regfile;
  logic [DW-1:0]     min_d, max_d, d;
  logic [IW-1:0]     min_j, min_k, max_j, max_k;
  logic [W-1:0]      word_j, word_k;
  logic              last_pair, first_pair;

  // Word 0 ends up in the top slice because bytes shift in from the bottom.
  assign word_j     = regfile[(N - 1 - int'(j)) * W +: W];
  assign word_k     = regfile[(N - 1 - int'(k)) * W +: W];
  assign last_pair  = (j == IW'(N - 2)) && (k == IW'(N - 1));
  assign first_pair = (j == '0) && (k == IW'(1));

  popcount_w #(.W(W)) u_popcount (
    .din   (word_j ^ word_k),
    .count (d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (!start)             nstate = LOAD;
      LOAD:    if (cnt == 16'(NB))     nstate = COMPARE;
      COMPARE: if (last_pair)          nstate = WRITE;
      WRITE:   if (cnt == 16'd5)       nstate = DONE;
      DONE:    if (start)              nstate = IDLE;
      default:                         nstate = IDLE;
    endcase
  end

  always_comb begin
    done        = (state == DONE);
    mem_wr_en   = (state == WRITE);
    mem_wr_data = '0;
    if (state == WRITE) begin
      case (cnt[2:0])
        RES_MIN:  mem_wr_data = 8'(min_d);
        RES_MAX:  mem_wr_data = 8'(max_d);
        RES_MINJ: mem_wr_data = 8'(min_j);
        RES_MINK: mem_wr_data = 8'(min_k);
        RES_MAXJ: mem_wr_data = 8'(max_j);
        RES_MAXK: mem_wr_data = 8'(max_k);
        default:  mem_wr_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      j        <= '0;
      k        <= '0;
      regfile  <= '0;
      min_d    <= '0;
      max_d    <= '0;
      min_j    <= '0;
      min_k    <= '0;
      max_j    <= '0;
      max_k    <= '0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt   <= '0;
          j     <= '0;
          k     <= IW'(1);
          min_d <= DW'(W);
          max_d <= '0;
          min_j <= '0;
          min_k <= '0;
          max_j <= '0;
          max_k <= '0;
          if (!start) mem_addr <= AW'(SRC_BASE);
        end
        LOAD: begin
          cnt <= cnt + 16'd1;
          if (cnt != '0) regfile <= {regfile[N*W-9:0], mem_rd_data};
          if (cnt < 16'(NB - 1)) mem_addr <= AW'(SRC_BASE + int'(cnt) + 1);
        end
        COMPARE: begin
          // The first pair is taken unconditionally so ties resolve to (0,1).
          if (first_pair || d < min_d) begin
            min_d <= d;
            min_j <= j;
            min_k <= k;
          end
          if (first_pair || d > max_d) begin
            max_d <= d;
            max_j <= j;
            max_k <= k;
          end
          if (k == IW'(N - 1)) begin
            j <= j + IW'(1);
            k <= j + IW'(2);
          end else begin
            k <= k + IW'(1);
          end
          if (last_pair) begin
            cnt      <= '0;
            mem_addr <= AW'(RES_BASE);
          end
        end
        WRITE: begin
          cnt <= cnt + 16'd1;
          if (cnt < 16'd5) mem_addr <= AW'(RES_BASE + int'(cnt) + 1);
        end
        default: ;
      endcase
    end
  end

endmodule
